debounce_scheduler: RTL
=======================

DEBOUNCE_SCHEDULER -- requirements
Module: debounce_scheduler

Interface
REQ-001 SHALL have parameter p_channels, default 8, number of debounced inputs (2..64).
REQ-002 SHALL have parameter p_scale, default 5, consecutive agreeing samples needed to switch a channel (2..255).
REQ-003 SHALL have parameter p_prescale, default 16, clock cycles per scan tick (>= p_channels+1).
REQ-004 SHALL have port i_clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_in  input  p_channels  raw asynchronous inputs.
REQ-007 SHALL have port i_clr  input  1  one-cycle pulse, clears sticky flags.
REQ-008 SHALL have port o_out  output  p_channels  debounced levels.
REQ-009 SHALL have port o_evt_valid  output  1  edge event pending.
REQ-010 SHALL have port o_evt_ch  output  $clog2(p_channels)  channel of pending event.
REQ-011 SHALL have port o_evt_rise  output  1  1 = rising, 0 = falling event.
REQ-012 SHALL have port i_evt_ready  input  1  consumer accepts event.
REQ-013 SHALL have port o_overrun  output  1  sticky: tick arrived during an unfinished scan.
REQ-014 SHALL have port o_evt_lost  output  1  sticky: event dropped because slot full.

Function
REQ-015 SHALL pass each i_in bit through a 2-flop synchronizer before sampling.
REQ-016 SHALL run prescaler 0..p_prescale-1, issuing one-cycle tick when it reaches p_prescale-1, then wrapping to 0.
REQ-017 SHALL implement scan FSM IDLE/SCAN: tick in IDLE -> SCAN with pointer 0; SCAN updates exactly one channel per cycle, pointer+1; after channel p_channels-1 -> IDLE.
REQ-018 SHALL ignore a tick arriving in SCAN and set o_overrun.
REQ-019 SHALL keep per channel a state START/LOW/RISE/HIGH/FALL and count of width $clog2(p_scale+1), updated only when that channel is visited.
REQ-020 SHALL apply on visit with synchronized sample s: START -> HIGH if s else LOW, count 0, no event.
REQ-021 SHALL apply LOW: s -> RISE, count 1; else stay.
REQ-022 SHALL apply RISE: s and count+1 == p_scale -> HIGH, count 0, rising event; s otherwise -> count+1; !s -> LOW, count 0.
REQ-023 SHALL apply HIGH: !s -> FALL, count 1; else stay.
REQ-024 SHALL apply FALL: !s and count+1 == p_scale -> LOW, count 0, falling event; !s otherwise -> count+1; s -> HIGH, count 0.
REQ-025 SHALL drive o_out[c] = 1 exactly when channel c is in HIGH or FALL, registered.
REQ-026 SHALL hold events in a one-entry slot: event loads o_evt_ch/o_evt_rise and sets o_evt_valid the cycle after the visit.
REQ-027 SHALL clear o_evt_valid on o_evt_valid && i_evt_ready; event and accept in same cycle -> new event loaded, valid stays 1.
REQ-028 SHALL drop a new event when o_evt_valid && !i_evt_ready, keep the pending one, set o_evt_lost.
REQ-029 SHALL clear o_overrun and o_evt_lost on i_clr; a set condition in the same cycle wins.

Reset
REQ-030 SHALL, on i_rst_n low, asynchronously force: all channels START, counts 0, prescaler 0, FSM IDLE, pointer 0, synchronizers 0, o_out 0, o_evt_valid 0, o_evt_ch 0, o_evt_rise 0, sticky flags 0.
REQ-031 SHALL discard any scan in progress when reset asserts mid-scan; first tick after release starts at channel 0.

Configuration
REQ-032 SHALL compile event slot only when DEBOUNCE_SCHED_EVENT_EN is defined.
REQ-033 SHALL, without DEBOUNCE_SCHED_EVENT_EN, keep all ports, tie o_evt_valid, o_evt_ch, o_evt_rise, o_evt_lost to 0, ignore i_evt_ready; debounce unchanged.

Verification (p_channels=4, p_scale=3, p_prescale=8, macro defined unless noted)
REQ-034 SHALL cover: i_in=4'b0101 held from reset -> after first scan o_out=4'b0101, no event.
REQ-035 SHALL cover: ch2 0->1 held steady -> o_out[2] rises on third visit after change; o_evt_valid=1, o_evt_ch=2, o_evt_rise=1.
REQ-036 SHALL cover: ch1 high glitch for 2 visits -> o_out[1] stays 0, no event.
REQ-037 SHALL cover: ch0 and ch3 fall in same scan with i_evt_ready=0 -> event ch0 rise=0 held, ch3 dropped, o_evt_lost=1; i_clr -> 0.
REQ-038 SHALL cover: i_rst_n low at pointer 2 mid-scan -> all outputs 0 immediately; next scan starts at channel 0.
REQ-039 SHALL cover: macro undefined, scenario REQ-035 -> o_out[2] rises, o_evt_valid stays 0.

Source files
------------

// File: rtl/debounce_scheduler.sv
// Time-multiplexed input debouncer: one channel is updated per cycle during a scan.
// The edge-event slot is compiled only when DEBOUNCE_SCHED_EVENT_EN is defined.
module debounce_scheduler #(
    parameter int unsigned p_channels = 8,
    parameter int unsigned p_scale    = 5,
    parameter int unsigned p_prescale = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [p_channels-1:0]         i_in,
    input  logic                          i_clr,
    output logic [p_channels-1:0]         o_out,
    output logic                          o_evt_valid,
    output logic [$clog2(p_channels)-1:0] o_evt_ch,
    output logic                          o_evt_rise,
    input  logic                          i_evt_ready,
    output logic                          o_overrun,
    output logic                          o_evt_lost
);
    localparam int unsigned ChW  = $clog2(p_channels);
    localparam int unsigned CntW = $clog2(p_scale + 1);
    localparam int unsigned PsW  = $clog2(p_prescale);

    typedef enum logic [2:0] {StStart, StLow, StRise, StHigh, StFall} ch_state_e;
    typedef enum logic {ScIdle, ScScan} scan_state_e;

    logic [p_channels-1:0] sync1_q, sync2_q;
    logic [PsW-1:0]        presc_q;
    logic                  tick;
    scan_state_e           scan_q, scan_d;
    logic [ChW-1:0]        ptr_q, ptr_d;
    logic                  visit;
    logic                  overrun_set;
    logic                  overrun_q;

    ch_state_e             ch_q  [p_channels];
    logic [CntW-1:0]       cnt_q [p_channels];
    logic [p_channels-1:0] out_q;

    ch_state_e             cur_st, nxt_st;
    logic [CntW-1:0]       cur_cnt, nxt_cnt, cnt_inc;
    logic                  smp;
    logic                  evt_fire, evt_rise;

    assign tick  = (presc_q == PsW'(p_prescale - 1));
    assign visit = (scan_q == ScScan);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            presc_q <= '0;
            scan_q  <= ScIdle;
            ptr_q   <= '0;
        end else begin
            sync1_q <= i_in;
            sync2_q <= sync1_q;
            presc_q <= tick ? '0 : presc_q + PsW'(1);
            scan_q  <= scan_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        scan_d      = scan_q;
        ptr_d       = ptr_q;
        overrun_set = 1'b0;
        case (scan_q)
            ScIdle: begin
                if (tick) begin
                    scan_d = ScScan;
                    ptr_d  = '0;
                end
            end
            ScScan: begin
                overrun_set = tick;
                if (ptr_q == ChW'(p_channels - 1)) begin
                    scan_d = ScIdle;
                    ptr_d  = '0;
                end else begin
                    ptr_d = ptr_q + ChW'(1);
                end
            end
            default: begin
                scan_d = ScIdle;
                ptr_d  = '0;
            end
        endcase
    end

    // Next state of the single channel currently selected by the scan pointer.
    assign cur_st  = ch_q[ptr_q];
    assign cur_cnt = cnt_q[ptr_q];
    assign smp     = sync2_q[ptr_q];
    assign cnt_inc = cur_cnt + CntW'(1);

    always_comb begin
        nxt_st   = cur_st;
        nxt_cnt  = cur_cnt;
        evt_fire = 1'b0;
        evt_rise = 1'b0;
        case (cur_st)
            StStart: begin
                nxt_st  = smp ? StHigh : StLow;
                nxt_cnt = '0;
            end
            StLow: begin
                if (smp) begin
                    nxt_st  = StRise;
                    nxt_cnt = CntW'(1);
                end
            end
            StRise: begin
                if (!smp) begin
                    nxt_st  = StLow;
                    nxt_cnt = '0;
                end else if (cnt_inc == CntW'(p_scale)) begin
                    nxt_st   = StHigh;
                    nxt_cnt  = '0;
                    evt_fire = visit;
                    evt_rise = 1'b1;
                end else begin
                    nxt_cnt = cnt_inc;
                end
            end
            StHigh: begin
                if (!smp) begin
                    nxt_st  = StFall;
                    nxt_cnt = CntW'(1);
                end
            end
            StFall: begin
                if (smp) begin
                    nxt_st  = StHigh;
                    nxt_cnt = '0;
                end else if (cnt_inc == CntW'(p_scale)) begin
                    nxt_st   = StLow;
                    nxt_cnt  = '0;
                    evt_fire = visit;
                end else begin
                    nxt_cnt = cnt_inc;
                end
            end
            default: begin
                nxt_st  = StStart;
                nxt_cnt = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int c = 0; c < p_channels; c++) begin
                ch_q[c]  <= StStart;
                cnt_q[c] <= '0;
            end
            out_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (visit) begin
                ch_q[ptr_q]  <= nxt_st;
                cnt_q[ptr_q] <= nxt_cnt;
                out_q[ptr_q] <= (nxt_st == StHigh) || (nxt_st == StFall);
            end
            overrun_q <= overrun_set | (overrun_q & ~i_clr);
        end
    end

    assign o_out     = out_q;
    assign o_overrun = overrun_q;

`ifdef DEBOUNCE_SCHED_EVENT_EN
    logic           evt_valid_q, evt_rise_q, evt_lost_q;
    logic [ChW-1:0] evt_ch_q;
    logic           evt_load, evt_drop;

    assign evt_load = evt_fire && (!evt_valid_q || i_evt_ready);
    assign evt_drop = evt_fire && evt_valid_q && !i_evt_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            evt_valid_q <= 1'b0;
            evt_ch_q    <= '0;
            evt_rise_q  <= 1'b0;
            evt_lost_q  <= 1'b0;
        end else begin
            if (evt_load) begin
                evt_valid_q <= 1'b1;
                evt_ch_q    <= ptr_q;
                evt_rise_q  <= evt_rise;
            end else if (evt_valid_q && i_evt_ready) begin
                evt_valid_q <= 1'b0;
            end
            evt_lost_q <= evt_drop | (evt_lost_q & ~i_clr);
        end
    end

    assign o_evt_valid = evt_valid_q;
    assign o_evt_ch    = evt_ch_q;
    assign o_evt_rise  = evt_rise_q;
    assign o_evt_lost  = evt_lost_q;
`else
    logic unused_evt;
    assign unused_evt  = i_evt_ready ^ evt_fire ^ evt_rise;
    assign o_evt_valid = 1'b0;
    assign o_evt_ch    = '0;
    assign o_evt_rise  = 1'b0;
    assign o_evt_lost  = 1'b0;
`endif

endmodule
